alu_instr_sequencer: RTL and testbench
======================================

Name: alu_instr_sequencer

Overview:
Upstream control stage for the register-file + ALU datapath. Accepts 32-bit MIPS R-type instruction words over a valid/ready handshake and decodes rs/rt/rd/funct. Drives the datapath's read/write addresses, 3-bit ALU opcode and a single-cycle write strobe, then captures the ALU's OF/ZF into status flags. Replaces hand-toggled Write_Reg/address stimulus with a deterministic 4-state sequence.

Parameters:
CNT_W, 16, width of retired-instruction counter
SUPPRESS_OF_WRITE, 1, when 1 an ADD/SUB producing OF=1 does not write rd

Ports:
clk  in  1  system clock, rising edge
Reset  in  1  synchronous, active-low reset (Reset=0 at a rising edge resets)
instr_valid  in  1  upstream has an instruction on instr
instr  in  32  instruction word: [31:26] op, [25:21] rs, [20:16] rt, [15:11] rd, [5:0] funct
instr_ready  out  1  sequencer can accept an instruction
R_Addr_A  out  5  register-file read port A address (rs)
R_Addr_B  out  5  register-file read port B address (rt)
W_Addr  out  5  register-file write address (rd)
ALU_OP  out  3  ALU operation select
Write_Reg  out  1  register-file write enable, one-cycle pulse
OF  in  1  ALU overflow, combinational from current addresses/op
ZF  in  1  ALU zero flag
done  out  1  one-cycle pulse: instruction retired (written, suppressed, or illegal)
flag_of  out  1  OF captured for last executed instruction
flag_zf  out  1  ZF captured for last executed instruction
ill_instr  out  1  last accepted instruction was illegal
retired_cnt  out  CNT_W  count of done pulses, wraps 2^CNT_W-1 -> 0

Behaviour:
- Reset (Reset=0 at edge): state=IDLE; instr_ready=1; R_Addr_A/R_Addr_B/W_Addr=0; ALU_OP=0; Write_Reg=0; done=0; flag_of/flag_zf/ill_instr=0; retired_cnt=0. Applies mid-sequence: in-flight instruction is dropped, no write occurs after the resetting edge.
- States: IDLE -> DECODE -> EXEC -> WB -> IDLE. instr_ready=1 only in IDLE.
- IDLE: on instr_valid & instr_ready at edge T, latch instr; go DECODE.
- DECODE (cycle T+1): drive R_Addr_A=rs, R_Addr_B=rt, W_Addr=rd, ALU_OP=decoded; evaluate legality; go EXEC.
- EXEC (T+2): ALU outputs settled; at edge ending EXEC capture flag_of=OF, flag_zf=ZF; go WB.
- WB (T+3): Write_Reg=1 for exactly this cycle unless suppressed; done=1; retired_cnt++ at end of cycle; go IDLE. Next accept earliest at T+4 edge; throughput 1 instr / 4 cycles.
- Addresses and ALU_OP held stable DECODE through WB; hold last values in IDLE.
- Decode (op must be 0): funct 0x24 AND->000, 0x25 OR->001, 0x26 XOR->010, 0x27 NOR->011, 0x20 ADD->100, 0x22 SUB->101, 0x2B SLTU->110, 0x04 SLLV->111.
- Illegal (op!=0 or unmapped funct): ill_instr=1, ALU_OP=000, Write_Reg stays 0 in WB, flag_of/flag_zf forced 0, done still pulses, counter still increments. ill_instr cleared by next legal instruction.
- Write suppression: rd=0 never written; OF=1 on ADD/SUB with SUPPRESS_OF_WRITE=1 not written (flag_of still 1). OF ignored (flag_of=0) for non-ADD/SUB ops.
- instr_valid while not ready: ignored; upstream must hold instr until accepted.

Decomposition:
- Shared package: ALU_OP encodings (8 localparams), funct codes, R-type field bit positions, state encoding (2-bit IDLE/DECODE/EXEC/WB).
- One natural sub-module: rtype_decoder (combinational funct/op -> ALU_OP + legal bit). FSM, capture and counter stay in the top.

Test Plan:
- Reset=0 two cycles then 1 -> instr_ready=1, all outputs 0, retired_cnt=0.
- instr=0x00221820 (add rd=3,rs=1,rt=2) accepted at T -> T+1 R_Addr_A=1,R_Addr_B=2,W_Addr=3,ALU_OP=100; T+3 Write_Reg=1,done=1; retired_cnt=1; instr_ready=0 T+1..T+3.
- sub with stubbed OF=1 -> flag_of=1, Write_Reg stays 0, done=1; same with SUPPRESS_OF_WRITE=0 -> Write_Reg=1.
- instr=0x08000000 (op=2) -> ill_instr=1, Write_Reg never 1, done=1; follow with and rd=0 -> ill_instr=0, no write.
- Back-to-back valid held high with 3 instructions -> accepts spaced exactly 4 cycles, three single-cycle Write_Reg pulses, retired_cnt=3.
- Reset=0 during EXEC -> next cycle state IDLE, Write_Reg=0, done=0, retired_cnt unchanged from reset value 0; CNT_W=2 wraps 3->0 on fourth retire.

Source files
------------

// File: rtl/alu_instr_sequencer_pkg.sv
// Shared definitions for the R-type instruction sequencer: ALU opcode
// encodings, MIPS funct codes, instruction field positions and FSM states.
package alu_instr_sequencer_pkg;

  // ALU operation select driven onto the datapath
  localparam logic [2:0] ALU_AND  = 3'b000;
  localparam logic [2:0] ALU_OR   = 3'b001;
  localparam logic [2:0] ALU_XOR  = 3'b010;
  localparam logic [2:0] ALU_NOR  = 3'b011;
  localparam logic [2:0] ALU_ADD  = 3'b100;
  localparam logic [2:0] ALU_SUB  = 3'b101;
  localparam logic [2:0] ALU_SLTU = 3'b110;
  localparam logic [2:0] ALU_SLLV = 3'b111;

  // R-type primary opcode and the funct codes we execute
  localparam logic [5:0] OP_RTYPE    = 6'h00;
  localparam logic [5:0] FUNCT_AND   = 6'h24;
  localparam logic [5:0] FUNCT_OR    = 6'h25;
  localparam logic [5:0] FUNCT_XOR   = 6'h26;
  localparam logic [5:0] FUNCT_NOR   = 6'h27;
  localparam logic [5:0] FUNCT_ADD   = 6'h20;
  localparam logic [5:0] FUNCT_SUB   = 6'h22;
  localparam logic [5:0] FUNCT_SLTU  = 6'h2B;
  localparam logic [5:0] FUNCT_SLLV  = 6'h04;

  // Instruction word field positions
  localparam int OP_MSB    = 31;
  localparam int OP_LSB    = 26;
  localparam int RS_MSB    = 25;
  localparam int RS_LSB    = 21;
  localparam int RT_MSB    = 20;
  localparam int RT_LSB    = 16;
  localparam int RD_MSB    = 15;
  localparam int RD_LSB    = 11;
  localparam int SHAMT_MSB = 10;
  localparam int SHAMT_LSB = 6;
  localparam int FUNCT_MSB = 5;
  localparam int FUNCT_LSB = 0;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DECODE = 2'd1,
    ST_EXEC   = 2'd2,
    ST_WB     = 2'd3
  } state_t;

  // Only arithmetic ops have a meaningful overflow flag
  function automatic logic is_addsub(input logic [2:0] op);
    return (op == ALU_ADD) || (op == ALU_SUB);
  endfunction

endpackage

// File: rtl/alu_instr_sequencer_if.sv
// Bundle between upstream instruction source / register-file+ALU datapath
// and the sequencer. The sequencer uses the slave side.
interface alu_instr_sequencer_if #(
  parameter int CNT_W = 16
);
  logic             instr_valid;
  logic [31:0]      instr;
  logic             instr_ready;
  logic [4:0]       R_Addr_A;
  logic [4:0]       R_Addr_B;
  logic [4:0]       W_Addr;
  logic [2:0]       ALU_OP;
  logic             Write_Reg;
  logic             OF;
  logic             ZF;
  logic             done;
  logic             flag_of;
  logic             flag_zf;
  logic             ill_instr;
  logic [CNT_W-1:0] retired_cnt;

  modport slave (
    input  instr_valid, instr, OF, ZF,
    output instr_ready, R_Addr_A, R_Addr_B, W_Addr, ALU_OP, Write_Reg,
           done, flag_of, flag_zf, ill_instr, retired_cnt
  );

  modport master (
    output instr_valid, instr, OF, ZF,
    input  instr_ready, R_Addr_A, R_Addr_B, W_Addr, ALU_OP, Write_Reg,
           done, flag_of, flag_zf, ill_instr, retired_cnt
  );
endinterface

// File: rtl/alu_instr_sequencer_rtype_decoder.sv
// Combinational R-type decode: op/funct -> ALU opcode plus a legal bit.
// Anything unrecognised decodes to ALU_AND with legal deasserted.
module alu_instr_sequencer_rtype_decoder
  import alu_instr_sequencer_pkg::*;
(
  input  logic [5:0] op_i,
  input  logic [5:0] funct_i,
  output logic [2:0] alu_op_o,
  output logic       legal_o
);

  // Map funct to ALU opcode; non-zero op or unknown funct is illegal
  always_comb begin
    alu_op_o = ALU_AND;
    legal_o  = 1'b0;
    if (op_i == OP_RTYPE) begin
      legal_o = 1'b1;
      case (funct_i)
        FUNCT_AND:  alu_op_o = ALU_AND;
        FUNCT_OR:   alu_op_o = ALU_OR;
        FUNCT_XOR:  alu_op_o = ALU_XOR;
        FUNCT_NOR:  alu_op_o = ALU_NOR;
        FUNCT_ADD:  alu_op_o = ALU_ADD;
        FUNCT_SUB:  alu_op_o = ALU_SUB;
        FUNCT_SLTU: alu_op_o = ALU_SLTU;
        FUNCT_SLLV: alu_op_o = ALU_SLLV;
        default: begin
          alu_op_o = ALU_AND;
          legal_o  = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/alu_instr_sequencer.sv
// Control stage for the register-file + ALU datapath. Accepts one R-type
// instruction every four cycles (IDLE -> DECODE -> EXEC -> WB), drives
// addresses/opcode, captures OF/ZF and issues a single-cycle write strobe.
module alu_instr_sequencer
  import alu_instr_sequencer_pkg::*;
#(
  parameter int CNT_W             = 16,
  parameter bit SUPPRESS_OF_WRITE = 1'b1
) (
  input  logic                 clk,
  input  logic                 Reset,
  alu_instr_sequencer_if.slave bus
);

  state_t           state_q, state_d;
  logic [4:0]       r_addr_a_q, r_addr_b_q, w_addr_q;
  logic [2:0]       alu_op_q;
  logic             legal_q;
  logic             flag_of_q, flag_zf_q, ill_instr_q;
  logic [CNT_W-1:0] retired_cnt_q;

  logic             instr_ready_d;
  logic             write_reg_d;
  logic             done_d;
  logic             accept;
  logic [2:0]       dec_alu_op;
  logic             dec_legal;

  // shamt is not used by any supported operation
  logic             unused_shamt;
  assign unused_shamt = ^bus.instr[SHAMT_MSB:SHAMT_LSB];

  alu_instr_sequencer_rtype_decoder u_decoder (
    .op_i     (bus.instr[OP_MSB:OP_LSB]),
    .funct_i  (bus.instr[FUNCT_MSB:FUNCT_LSB]),
    .alu_op_o (dec_alu_op),
    .legal_o  (dec_legal)
  );

  assign accept = (state_q == ST_IDLE) && bus.instr_valid;

  // State register; reset drops any in-flight instruction
  always_ff @(posedge clk) begin
    if (!Reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next state plus ready / write strobe / retire pulse
  always_comb begin
    state_d       = state_q;
    instr_ready_d = 1'b0;
    write_reg_d   = 1'b0;
    done_d        = 1'b0;
    case (state_q)
      ST_IDLE: begin
        instr_ready_d = 1'b1;
        if (bus.instr_valid) state_d = ST_DECODE;
      end
      ST_DECODE: state_d = ST_EXEC;
      ST_EXEC:   state_d = ST_WB;
      ST_WB: begin
        done_d      = 1'b1;
        // rd=0 is hardwired zero; overflowing add/sub may be blocked
        write_reg_d = legal_q && (w_addr_q != 5'd0) &&
                      !(SUPPRESS_OF_WRITE && is_addsub(alu_op_q) && flag_of_q);
        state_d     = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Latch decoded fields on accept, capture flags at end of EXEC, count retires
  always_ff @(posedge clk) begin
    if (!Reset) begin
      r_addr_a_q    <= '0;
      r_addr_b_q    <= '0;
      w_addr_q      <= '0;
      alu_op_q      <= ALU_AND;
      legal_q       <= 1'b0;
      flag_of_q     <= 1'b0;
      flag_zf_q     <= 1'b0;
      ill_instr_q   <= 1'b0;
      retired_cnt_q <= '0;
    end else begin
      if (accept) begin
        r_addr_a_q <= bus.instr[RS_MSB:RS_LSB];
        r_addr_b_q <= bus.instr[RT_MSB:RT_LSB];
        w_addr_q   <= bus.instr[RD_MSB:RD_LSB];
        alu_op_q   <= dec_alu_op;
        legal_q    <= dec_legal;
      end
      if (state_q == ST_DECODE) ill_instr_q <= !legal_q;
      if (state_q == ST_EXEC) begin
        flag_of_q <= legal_q && is_addsub(alu_op_q) && bus.OF;
        flag_zf_q <= legal_q && bus.ZF;
      end
      if (state_q == ST_WB) retired_cnt_q <= retired_cnt_q + CNT_W'(1);
    end
  end

  assign bus.instr_ready = instr_ready_d;
  assign bus.R_Addr_A    = r_addr_a_q;
  assign bus.R_Addr_B    = r_addr_b_q;
  assign bus.W_Addr      = w_addr_q;
  assign bus.ALU_OP      = alu_op_q;
  assign bus.Write_Reg   = write_reg_d;
  assign bus.done        = done_d;
  assign bus.flag_of     = flag_of_q;
  assign bus.flag_zf     = flag_zf_q;
  assign bus.ill_instr   = ill_instr_q;
  assign bus.retired_cnt = retired_cnt_q;

endmodule

// File: tb/tb_alu_instr_sequencer.sv
// Bench for alu_instr_sequencer. Two instances share one stimulus stream:
// dut_a (CNT_W=16, overflow writes suppressed) and dut_b (CNT_W=2, overflow
// writes allowed), so suppression and counter wrap are seen side by side.
module tb_alu_instr_sequencer;

  typedef struct {
    logic [31:0] ins;
    logic        of_in;
    logic        zf_in;
    logic [2:0]  op;
    logic        ill;
    logic        wr_a;
    logic        wr_b;
    logic        fof;
    logic        fzf;
  } vec_t;

  logic        clk = 1'b0;
  logic        Reset = 1'b0;
  logic        valid = 1'b0;
  logic [31:0] instr = 32'h0;
  logic        of_in = 1'b0;
  logic        zf_in = 1'b0;

  int n_vec = 0;
  int n_miss = 0;
  int cyc = 0;
  int exp_cnt_a = 0;
  int exp_cnt_b = 0;
  int last_acc = 0;
  bit chained = 1'b0;
  vec_t tbl[12];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  alu_instr_sequencer_if #(.CNT_W(16)) ifa ();
  alu_instr_sequencer_if #(.CNT_W(2))  ifb ();

  assign ifa.instr_valid = valid;
  assign ifa.instr       = instr;
  assign ifa.OF          = of_in;
  assign ifa.ZF          = zf_in;
  assign ifb.instr_valid = valid;
  assign ifb.instr       = instr;
  assign ifb.OF          = of_in;
  assign ifb.ZF          = zf_in;

  alu_instr_sequencer #(.CNT_W(16), .SUPPRESS_OF_WRITE(1'b1)) dut_a (
    .clk(clk), .Reset(Reset), .bus(ifa.slave)
  );
  alu_instr_sequencer #(.CNT_W(2), .SUPPRESS_OF_WRITE(1'b0)) dut_b (
    .clk(clk), .Reset(Reset), .bus(ifb.slave)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Same expectation on both instances
  task automatic check2(input string name, input logic [31:0] act_a,
                        input logic [31:0] act_b, input logic [31:0] exp);
    check({"a.", name}, act_a, exp);
    check({"b.", name}, act_b, exp);
  endtask

  function automatic logic [31:0] rt_ins(input logic [4:0] rs, input logic [4:0] rt,
                                         input logic [4:0] rd, input logic [5:0] fn);
    return {6'd0, rs, rt, rd, 5'd0, fn};
  endfunction

  function automatic vec_t mkv(input logic [31:0] ins, input logic o, input logic z,
                               input logic [2:0] op, input logic ill, input logic wa,
                               input logic wb, input logic fo, input logic fz);
    vec_t v;
    v.ins = ins; v.of_in = o; v.zf_in = z; v.op = op; v.ill = ill;
    v.wr_a = wa; v.wr_b = wb; v.fof = fo; v.fzf = fz;
    return v;
  endfunction

  // One full instruction, entered and left at a negedge in IDLE.
  // hold keeps instr_valid high throughout (back-to-back upstream).
  task automatic run_vec(input vec_t v, input bit hold);
    logic [4:0] rs, rt, rd;
    rs = v.ins[25:21];
    rt = v.ins[20:16];
    rd = v.ins[15:11];
    check2("ready_idle", 32'(ifa.instr_ready), 32'(ifb.instr_ready), 32'd1);
    instr = v.ins; of_in = v.of_in; zf_in = v.zf_in; valid = 1'b1;
    @(posedge clk);
    @(negedge clk); // DECODE
    if (chained) check("accept_spacing", 32'(cyc - last_acc), 32'd4);
    last_acc = cyc;
    chained  = hold;
    if (!hold) valid = 1'b0;
    check2("ready_dec", 32'(ifa.instr_ready), 32'(ifb.instr_ready), 32'd0);
    check2("R_Addr_A", 32'(ifa.R_Addr_A), 32'(ifb.R_Addr_A), 32'(rs));
    check2("R_Addr_B", 32'(ifa.R_Addr_B), 32'(ifb.R_Addr_B), 32'(rt));
    check2("W_Addr", 32'(ifa.W_Addr), 32'(ifb.W_Addr), 32'(rd));
    check2("ALU_OP", 32'(ifa.ALU_OP), 32'(ifb.ALU_OP), 32'(v.op));
    check2("wr_dec", 32'(ifa.Write_Reg), 32'(ifb.Write_Reg), 32'd0);
    check2("done_dec", 32'(ifa.done), 32'(ifb.done), 32'd0);
    @(negedge clk); // EXEC
    check2("ready_exec", 32'(ifa.instr_ready), 32'(ifb.instr_ready), 32'd0);
    check2("wr_exec", 32'(ifa.Write_Reg), 32'(ifb.Write_Reg), 32'd0);
    check2("done_exec", 32'(ifa.done), 32'(ifb.done), 32'd0);
    check2("ill_exec", 32'(ifa.ill_instr), 32'(ifb.ill_instr), 32'(v.ill));
    @(negedge clk); // WB
    check("a.wr_wb", 32'(ifa.Write_Reg), 32'(v.wr_a));
    check("b.wr_wb", 32'(ifb.Write_Reg), 32'(v.wr_b));
    check2("done_wb", 32'(ifa.done), 32'(ifb.done), 32'd1);
    check2("ready_wb", 32'(ifa.instr_ready), 32'(ifb.instr_ready), 32'd0);
    check2("flag_of", 32'(ifa.flag_of), 32'(ifb.flag_of), 32'(v.fof));
    check2("flag_zf", 32'(ifa.flag_zf), 32'(ifb.flag_zf), 32'(v.fzf));
    check2("ALU_OP_wb", 32'(ifa.ALU_OP), 32'(ifb.ALU_OP), 32'(v.op));
    check2("W_Addr_wb", 32'(ifa.W_Addr), 32'(ifb.W_Addr), 32'(rd));
    exp_cnt_a = (exp_cnt_a + 1) % 65536;
    exp_cnt_b = (exp_cnt_b + 1) % 4;
    @(negedge clk); // IDLE again
    check2("wr_idle", 32'(ifa.Write_Reg), 32'(ifb.Write_Reg), 32'd0);
    check2("done_idle", 32'(ifa.done), 32'(ifb.done), 32'd0);
    check2("ready_after", 32'(ifa.instr_ready), 32'(ifb.instr_ready), 32'd1);
    check("a.retired_cnt", 32'(ifa.retired_cnt), 32'(exp_cnt_a));
    check("b.retired_cnt", 32'(ifb.retired_cnt), 32'(exp_cnt_b));
    check2("ill_idle", 32'(ifa.ill_instr), 32'(ifb.ill_instr), 32'(v.ill));
    check2("flag_of_hold", 32'(ifa.flag_of), 32'(ifb.flag_of), 32'(v.fof));
    check2("ALU_OP_hold", 32'(ifa.ALU_OP), 32'(ifb.ALU_OP), 32'(v.op));
    $display("instr %08h retired: op=%0d ill=%0d wr_a=%0d wr_b=%0d cnt_a=%0d cnt_b=%0d",
             v.ins, ifa.ALU_OP, ifa.ill_instr, v.wr_a, v.wr_b, ifa.retired_cnt, ifb.retired_cnt);
  endtask

  task automatic check_reset_state(input string tag);
    check2({tag, ".ready"}, 32'(ifa.instr_ready), 32'(ifb.instr_ready), 32'd1);
    check2({tag, ".R_Addr_A"}, 32'(ifa.R_Addr_A), 32'(ifb.R_Addr_A), 32'd0);
    check2({tag, ".R_Addr_B"}, 32'(ifa.R_Addr_B), 32'(ifb.R_Addr_B), 32'd0);
    check2({tag, ".W_Addr"}, 32'(ifa.W_Addr), 32'(ifb.W_Addr), 32'd0);
    check2({tag, ".ALU_OP"}, 32'(ifa.ALU_OP), 32'(ifb.ALU_OP), 32'd0);
    check2({tag, ".Write_Reg"}, 32'(ifa.Write_Reg), 32'(ifb.Write_Reg), 32'd0);
    check2({tag, ".done"}, 32'(ifa.done), 32'(ifb.done), 32'd0);
    check2({tag, ".flag_of"}, 32'(ifa.flag_of), 32'(ifb.flag_of), 32'd0);
    check2({tag, ".flag_zf"}, 32'(ifa.flag_zf), 32'(ifb.flag_zf), 32'd0);
    check2({tag, ".ill_instr"}, 32'(ifa.ill_instr), 32'(ifb.ill_instr), 32'd0);
    check2({tag, ".retired_cnt"}, 32'(ifa.retired_cnt), 32'(ifb.retired_cnt), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // {instr, OF, ZF, ALU_OP, ill, write dut_a, write dut_b, flag_of, flag_zf}
    tbl[0]  = mkv(32'h00221820, 1'b0, 1'b0, 3'b100, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    tbl[1]  = mkv(rt_ins(5'd6, 5'd7, 5'd5, 6'h22), 1'b1, 1'b0, 3'b101, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    tbl[2]  = mkv(32'h08000000, 1'b1, 1'b1, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    tbl[3]  = mkv(rt_ins(5'd4, 5'd4, 5'd0, 6'h24), 1'b1, 1'b1, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    tbl[4]  = mkv(rt_ins(5'd8, 5'd9, 5'd31, 6'h25), 1'b0, 1'b1, 3'b001, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    tbl[5]  = mkv(rt_ins(5'd11, 5'd12, 5'd10, 6'h26), 1'b1, 1'b0, 3'b010, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    tbl[6]  = mkv(rt_ins(5'd2, 5'd3, 5'd1, 6'h27), 1'b0, 1'b0, 3'b011, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    tbl[7]  = mkv(rt_ins(5'd13, 5'd14, 5'd4, 6'h20), 1'b1, 1'b1, 3'b100, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    tbl[8]  = mkv(rt_ins(5'd15, 5'd16, 5'd6, 6'h2B), 1'b0, 1'b1, 3'b110, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    tbl[9]  = mkv(rt_ins(5'd17, 5'd18, 5'd7, 6'h04), 1'b0, 1'b0, 3'b111, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    tbl[10] = mkv(rt_ins(5'd1, 5'd2, 5'd3, 6'h21), 1'b1, 1'b1, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    tbl[11] = mkv(rt_ins(5'd19, 5'd20, 5'd2, 6'h25), 1'b0, 1'b0, 3'b001, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);

    // Power-on reset: two cycles low, then release
    Reset = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    Reset = 1'b1;
    check_reset_state("reset");

    // Back-to-back: valid never drops, accepts must be 4 cycles apart
    run_vec(tbl[0], 1'b1);
    run_vec(tbl[4], 1'b1);
    run_vec(tbl[8], 1'b0);
    check("b2b.retired_cnt", 32'(ifa.retired_cnt), 32'd3);

    // Table sweep (includes illegal -> legal rd=0 pair and dut_b wrap)
    for (int i = 0; i < 12; i++) run_vec(tbl[i], 1'b0);

    // Reset asserted during EXEC: in-flight instruction must not write
    check("pre_rst.retired_cnt", 32'(ifa.retired_cnt), 32'd15);
    instr = tbl[0].ins; of_in = 1'b0; zf_in = 1'b0; valid = 1'b1;
    @(posedge clk);
    @(negedge clk); // DECODE
    valid = 1'b0;
    @(negedge clk); // EXEC
    Reset = 1'b0;
    @(negedge clk);
    Reset = 1'b1;
    check_reset_state("mid_rst");
    @(negedge clk);
    check2("post_rst.Write_Reg", 32'(ifa.Write_Reg), 32'(ifb.Write_Reg), 32'd0);
    check2("post_rst.done", 32'(ifa.done), 32'(ifb.done), 32'd0);
    check2("post_rst.retired_cnt", 32'(ifa.retired_cnt), 32'(ifb.retired_cnt), 32'd0);
    $display("reset during EXEC: cnt_a=%0d cnt_b=%0d", ifa.retired_cnt, ifb.retired_cnt);
    exp_cnt_a = 0;
    exp_cnt_b = 0;
    chained   = 1'b0;

    // Four retires: 2-bit counter goes 1,2,3,0
    for (int i = 0; i < 4; i++) run_vec(tbl[5 + i], 1'b0);
    check("wrap.a.retired_cnt", 32'(ifa.retired_cnt), 32'd4);
    check("wrap.b.retired_cnt", 32'(ifb.retired_cnt), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
